// File: rtl/regs_wr_arbiter_if.sv
// Write-port bus between the requesters and the register-file write arbiter.
// master: requester side (drives hold/vld/addr*/data*, observes grant and write triple)
// slave : arbiter side   (observes requests, drives rdy, WE/Addr_W/Di, inflight, last_gnt)
interface regs_wr_arbiter_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 3,
    parameter int unsigned NREQ = 3
);
    localparam int unsigned NREG = 1 << AW;

    logic                hold;
    logic [NREQ-1:0]     vld;
    logic [AW-1:0]       addr0;
    logic [AW-1:0]       addr1;
    logic [AW-1:0]       addr2;
    logic [DW-1:0]       data0;
    logic [DW-1:0]       data1;
    logic [DW-1:0]       data2;
    logic [NREQ-1:0]     rdy;
    logic                WE;
    logic [AW-1:0]       Addr_W;
    logic [DW-1:0]       Di;
    logic [NREG-1:0]     inflight;
    logic [1:0]          last_gnt;

    modport master (
        output hold, vld, addr0, addr1, addr2, data0, data1, data2,
        input  rdy, WE, Addr_W, Di, inflight, last_gnt
    );

    modport slave (
        input  hold, vld, addr0, addr1, addr2, data0, data1, data2,
        output rdy, WE, Addr_W, Di, inflight, last_gnt
    );
endinterface

// File: rtl/regs_wr_arbiter.sv
// Round-robin arbiter for the single write port of the 8 x 32 register file.
// Ports:
//   clk  - system clock, rising edge
//   cr   - asynchronous active-low reset
//   bus  - slave side of regs_wr_arbiter_if: requests in, combinational rdy out,
//          registered WE/Addr_W/Di triple, inflight one-hot mask, last_gnt index
module regs_wr_arbiter #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 3,
    parameter int unsigned NREQ = 3
) (
    input  logic             clk,
    input  logic             cr,
    regs_wr_arbiter_if.slave bus
);
    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned PW   = 2;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic            xfer;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] rdy_c;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            we_q;
    logic            we_nxt;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_nxt;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   data_nxt;
    logic [NREG-1:0] infl_q;
    logic [NREG-1:0] infl_nxt;
    logic [PW-1:0]   last_q;
    logic [PW-1:0]   last_nxt;

    // Grant: first valid requester scanning from ptr upward (mod NREQ); rdy is
    // forced low during reset so nothing is accepted that would then be lost.
    always_comb begin
        xfer    = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        rdy_c   = '0;
        if (cr && !bus.hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = PW'((32'(ptr) + k) % NREQ);
                if (!xfer && bus.vld[cand]) begin
                    xfer        = 1'b1;
                    gnt_idx     = cand;
                    rdy_c[cand] = 1'b1;
                end
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_addr = bus.addr0;
        sel_data = bus.data0;
        case (gnt_idx)
            2'd1: begin
                sel_addr = bus.addr1;
                sel_data = bus.data1;
            end
            2'd2: begin
                sel_addr = bus.addr2;
                sel_data = bus.data2;
            end
            default: ;
        endcase
    end

    // Next state: a transfer loads the write triple and advances ptr past the winner.
    always_comb begin
        ptr_nxt  = ptr;
        we_nxt   = 1'b0;
        addr_nxt = addr_q;
        data_nxt = data_q;
        infl_nxt = '0;
        last_nxt = last_q;
        if (xfer) begin
            ptr_nxt  = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
            we_nxt   = 1'b1;
            addr_nxt = sel_addr;
            data_nxt = sel_data;
            infl_nxt = NREG'(1) << sel_addr;
            last_nxt = gnt_idx;
        end
    end

    // State registers; reset aborts any write accepted in the current cycle.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            ptr    <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            infl_q <= '0;
            last_q <= 2'd3;
        end else begin
            ptr    <= ptr_nxt;
            we_q   <= we_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            infl_q <= infl_nxt;
            last_q <= last_nxt;
        end
    end

    assign bus.rdy      = rdy_c;
    assign bus.WE       = we_q;
    assign bus.Addr_W   = addr_q;
    assign bus.Di       = data_q;
    assign bus.inflight = infl_q;
    assign bus.last_gnt = last_q;
endmodule
